// File: rtl/swipt_pkg.sv
// swipt_pkg: shared definitions for the SWIPT receive decoder.
// Holds the FSM state encoding, the default frame sync pattern and the register index map.
// Pure constants; no logic, no latency, no flow control.
package swipt_pkg;

  // Decoder FSM states
  localparam logic [2:0] ST_HUNT   = 3'd0;
  localparam logic [2:0] ST_INDEX  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Frame start pattern
  localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;

  // Register indices carried in the frame index field; anything above the last one is rejected
  localparam logic [3:0] SWIPT_P_TX        = 4'd0;
  localparam logic [3:0] SWIPT_DUTY        = 4'd1;
  localparam logic [3:0] SWIPT_FREQ        = 4'd2;
  localparam logic [3:0] SWIPT_ASCII       = 4'd3;
  localparam logic [3:0] ANC_MAX_HEIGHT    = 4'd4;
  localparam logic [3:0] ANC_MIN_HEIGHT    = 4'd5;
  localparam logic [3:0] COMMS_TRAJECT     = 4'd6;
  localparam logic [3:0] COMMS_QR_CODES    = 4'd7;
  localparam logic [3:0] COMMS_FLIGHT_TIME = 4'd8;

endpackage

// File: rtl/swipt_duty_slicer.sv
// swipt_duty_slicer: synchronises the carrier, measures each period and its high time, classifies it.
// Edge seen 2 clk after swipt_in rises; the symbol of the closed period is valid in that same cycle.
// No flow control: one symbol per carrier period, timeout is a level while no edge arrives.
module swipt_duty_slicer #(
  parameter logic [11:0] MAX_PERIOD = 12'hFFF
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_swipt,
  output logic o_edge,
  output logic o_sym,
  output logic o_timeout
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync_d;
  logic [11:0] r_period_cnt;
  logic [11:0] r_high_cnt;
  logic        w_rise;

  assign w_rise = r_sync2 & ~r_sync_d;

  // Two-flop synchroniser, edge history, and saturating period / high-time counters.
  // The rising-edge cycle opens the new period and counts as its first (high) cycle.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync_d     <= 1'b0;
      r_period_cnt <= 12'd0;
      r_high_cnt   <= 12'd0;
    end else begin
      r_sync1  <= i_swipt;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
      if (w_rise) begin
        r_period_cnt <= 12'd1;
        r_high_cnt   <= 12'd1;
      end else begin
        if (r_period_cnt != 12'hFFF) r_period_cnt <= r_period_cnt + 12'd1;
        if (r_sync2 && (r_high_cnt != 12'hFFF)) r_high_cnt <= r_high_cnt + 12'd1;
      end
    end
  end

  assign o_edge    = w_rise;
  // Symbol 1 when the carrier was high for more than half of the period just closed
  assign o_sym     = {r_high_cnt, 1'b0} > {1'b0, r_period_cnt};
  // An edge in the same cycle rescues the carrier, so it never counts as a timeout
  assign o_timeout = (r_period_cnt >= MAX_PERIOD) && !w_rise;

endmodule

// File: rtl/swipt_rx_decoder.sv
// swipt_rx_decoder: duty-cycle demodulator and frame decoder for the SWIPT carrier (SYNC, 4b index, 16b data).
// word_valid / frame_err fire 2 clk after the edge closing the last bit; optional parity via SWIPT_RX_PARITY_EN.
// No backpressure: strobes are single-cycle and word_idx/word_data hold until the next accepted word.
module swipt_rx_decoder
  import swipt_pkg::*;
#(
  parameter int          PERIODS_PER_BIT = 8,
  parameter logic [7:0]  SYNC_WORD       = SYNC_WORD_DEF,
  parameter logic [11:0] MAX_PERIOD      = 12'hFFF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptAlive,
  input  logic        swipt_in,
  output logic        word_valid,
  output logic [3:0]  word_idx,
  output logic [15:0] word_data,
  output logic        frame_err,
  output logic        carrier_ok
);

  localparam int CW = $clog2(PERIODS_PER_BIT + 1);

  logic          w_edge;
  logic          w_sym;
  logic          w_timeout;
  logic          w_lost;
  logic          w_sym_vld;
  logic          w_bit_vld;
  logic          w_bit;
  logic          w_accept;
  logic [CW-1:0] w_ones_next;
  logic [7:0]    w_sync_next;

  logic [2:0]    r_state;
  logic          r_aligned;
  logic [CW-1:0] r_sym_cnt;
  logic [CW-1:0] r_ones;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_sync_sr;
  logic [3:0]    r_idx;
  logic [15:0]   r_data;
`ifdef SWIPT_RX_PARITY_EN
  logic          r_par;
`endif
  logic          r_word_valid;
  logic [3:0]    r_word_idx;
  logic [15:0]   r_word_data;
  logic          r_frame_err;
  logic          r_carrier_ok;

  swipt_duty_slicer #(.MAX_PERIOD(MAX_PERIOD)) u_slicer (
    .clk       (clk),
    .nrst      (nrst),
    .i_swipt   (swipt_in),
    .o_edge    (w_edge),
    .o_sym     (w_sym),
    .o_timeout (w_timeout)
  );

  // Link down is handled exactly like a carrier timeout, minus the error strobe
  assign w_lost      = w_timeout | ~swiptAlive;
  // The aligning edge only opens the first period; later edges each close one symbol
  assign w_sym_vld   = w_edge & r_aligned & ~w_lost;
  assign w_ones_next = r_ones + CW'(w_sym);
  assign w_bit_vld   = w_sym_vld && (r_sym_cnt == CW'(PERIODS_PER_BIT - 1));
  // Strict majority; an even split decodes as 0
  assign w_bit       = (32'(w_ones_next) << 1) > 32'(PERIODS_PER_BIT);
  assign w_sync_next = {r_sync_sr[6:0], w_bit};

`ifdef SWIPT_RX_PARITY_EN
  assign w_accept = (r_idx <= COMMS_FLIGHT_TIME) && !(^{r_idx, r_data, r_par});
`else
  assign w_accept = (r_idx <= COMMS_FLIGHT_TIME);
`endif

  // Bit alignment, symbol majority counting, frame FSM and output strobes
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= ST_HUNT;
      r_aligned    <= 1'b0;
      r_sym_cnt    <= '0;
      r_ones       <= '0;
      r_bit_cnt    <= 4'd0;
      r_sync_sr    <= 8'd0;
      r_idx        <= 4'd0;
      r_data       <= 16'd0;
`ifdef SWIPT_RX_PARITY_EN
      r_par        <= 1'b0;
`endif
      r_word_valid <= 1'b0;
      r_word_idx   <= 4'd0;
      r_word_data  <= 16'd0;
      r_frame_err  <= 1'b0;
      r_carrier_ok <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_lost) begin
        r_carrier_ok <= 1'b0;
        r_aligned    <= 1'b0;
        r_sym_cnt    <= '0;
        r_ones       <= '0;
        r_bit_cnt    <= 4'd0;
        r_sync_sr    <= 8'd0;
        r_state      <= ST_HUNT;
        r_frame_err  <= w_timeout && (r_state != ST_HUNT);
      end else begin
        if (w_edge) r_carrier_ok <= 1'b1;
        if (w_edge && !r_aligned) begin
          r_aligned <= 1'b1;
          r_sym_cnt <= '0;
          r_ones    <= '0;
        end else if (w_sym_vld) begin
          if (w_bit_vld) begin
            r_sym_cnt <= '0;
            r_ones    <= '0;
          end else begin
            r_sym_cnt <= r_sym_cnt + CW'(1);
            r_ones    <= w_ones_next;
          end
        end
        case (r_state)
          ST_HUNT: begin
            if (w_bit_vld) begin
              r_sync_sr <= w_sync_next;
              if (w_sync_next == SYNC_WORD) begin
                r_state   <= ST_INDEX;
                r_bit_cnt <= 4'd0;
              end
            end
          end
          ST_INDEX: begin
            if (w_bit_vld) begin
              r_idx     <= {r_idx[2:0], w_bit};
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd3) begin
                r_bit_cnt <= 4'd0;
                r_state   <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (w_bit_vld) begin
              r_data    <= {r_data[14:0], w_bit};
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd15) begin
                r_bit_cnt <= 4'd0;
`ifdef SWIPT_RX_PARITY_EN
                r_state   <= ST_PARITY;
`else
                r_state   <= ST_DONE;
`endif
              end
            end
          end
`ifdef SWIPT_RX_PARITY_EN
          ST_PARITY: begin
            if (w_bit_vld) begin
              r_par   <= w_bit;
              r_state <= ST_DONE;
            end
          end
`endif
          ST_DONE: begin
            if (w_accept) begin
              r_word_valid <= 1'b1;
              r_word_idx   <= r_idx;
              r_word_data  <= r_data;
            end else begin
              r_frame_err  <= 1'b1;
            end
            // Next frame re-aligns on a fresh edge and hunts from a clean sync register
            r_state   <= ST_HUNT;
            r_sync_sr <= 8'd0;
            r_aligned <= 1'b0;
            r_sym_cnt <= '0;
            r_ones    <= '0;
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

  assign word_valid = r_word_valid;
  assign word_idx   = r_word_idx;
  assign word_data  = r_word_data;
  assign frame_err  = r_frame_err;
  assign carrier_ok = r_carrier_ok;

endmodule

// File: tb/tb_swipt_rx_decoder.sv
// tb_swipt_rx_decoder: directed frames on a shortened (20 clk) carrier, expected strobes queued per frame.
// A negedge monitor pops the queue on every word_valid / frame_err and compares index and payload.
// Build with SWIPT_RX_PARITY_EN to append the parity bit and run the parity frames.
module tb_swipt_rx_decoder;
  import swipt_pkg::*;

  localparam int PPB     = 8;
  localparam int CARRIER = 20;
  localparam int HI1     = 16;
  localparam int HI0     = 4;
`ifdef SWIPT_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic        err;
    logic [3:0]  idx;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic        swiptAlive;
  logic        swipt_in;
  logic        word_valid;
  logic [3:0]  word_idx;
  logic [15:0] word_data;
  logic        frame_err;
  logic        carrier_ok;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  m_idx  = 4'd0;
  logic [15:0] m_data = 16'd0;

  swipt_rx_decoder #(
    .PERIODS_PER_BIT (PPB),
    .SYNC_WORD       (8'hA5),
    .MAX_PERIOD      (12'hFFF)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .swiptAlive (swiptAlive),
    .swipt_in   (swipt_in),
    .word_valid (word_valid),
    .word_idx   (word_idx),
    .word_data  (word_data),
    .frame_err  (frame_err),
    .carrier_ok (carrier_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_period(input int hi);
    swipt_in = 1'b1;
    repeat (hi) @(negedge clk);
    swipt_in = 1'b0;
    repeat (CARRIER - hi) @(negedge clk);
  endtask

  // n1/n0: how many of the PPB periods are sent at 80% duty for a 1 / 0 bit
  task automatic send_bit(input logic b, input int n1, input int n0);
    int n;
    n = b ? n1 : n0;
    for (int i = 0; i < PPB; i++) send_period((i < n) ? HI1 : HI0);
  endtask

  task automatic send_word(input logic [15:0] v, input int nbits, input int n1, input int n0);
    for (int i = nbits - 1; i >= 0; i--) send_bit(v[i], n1, n0);
  endtask

  task automatic send_head(input logic [3:0] idx);
    send_word(16'd0, 2, PPB, 0);
    send_word({8'd0, SYNC_WORD_DEF}, 8, PPB, 0);
    send_word({12'd0, idx}, 4, PPB, 0);
  endtask

  task automatic send_frame(input logic [3:0] idx, input logic [15:0] data, input int n1, input int n0,
                            input logic par_flip);
    exp_t e;
    e.err  = (idx > COMMS_FLIGHT_TIME) || (PAR_EN && par_flip);
    e.idx  = idx;
    e.data = data;
    q.push_back(e);
    send_head(idx);
    send_word(data, 16, n1, n0);
    if (PAR_EN) send_bit((^{idx, data}) ^ par_flip, PPB, 0);
    send_period(HI0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_word_valid"}, 32'(word_valid), 32'd0);
    chk({tag, "_frame_err"},  32'(frame_err),  32'd0);
    chk({tag, "_word_idx"},   32'(word_idx),   32'd0);
    chk({tag, "_word_data"},  32'(word_data),  32'd0);
    chk({tag, "_carrier_ok"}, 32'(carrier_ok), 32'd0);
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (nrst && (word_valid || frame_err)) begin
      if (q.size() == 0) begin
        chk("spurious_strobe", 32'({word_valid, frame_err}), 32'd0);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", 32'({word_valid, frame_err}), e.err ? 32'd1 : 32'd2);
        if (e.err) begin
          chk("err_idx_held",  32'(word_idx),  32'(m_idx));
          chk("err_data_held", 32'(word_data), 32'(m_data));
        end else begin
          chk("word_idx",  32'(word_idx),  32'(e.idx));
          chk("word_data", 32'(word_data), 32'(e.data));
          m_idx  = e.idx;
          m_data = e.data;
        end
      end
    end
  end

  initial begin
    exp_t abort;
    nrst       = 1'b0;
    swiptAlive = 1'b1;
    swipt_in   = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    nrst = 1'b1;

    // Nominal frame, then an out-of-range index, then the highest legal index
    send_frame(4'h2, 16'h1234, PPB, 0, 1'b0);
    chk("carrier_ok_running", 32'(carrier_ok), 32'd1);
    send_frame(4'hB, 16'hBEEF, PPB, 0, 1'b0);
    send_frame(4'h8, 16'h0F0F, PPB, 0, 1'b0);

    // Marginal majorities: 1 bits as 5/3, 0 bits as an even 4/4 split
    send_frame(4'h5, 16'hA5C3, 5, 4, 1'b0);

    // Carrier stops in the middle of DATA
    abort.err  = 1'b1;
    abort.idx  = 4'h3;
    abort.data = 16'h0;
    q.push_back(abort);
    send_head(4'h3);
    send_word(16'h001F, 5, PPB, 0);
    swipt_in = 1'b0;
    repeat (4096) @(negedge clk);
    chk("carrier_ok_lost", 32'(carrier_ok), 32'd0);
    send_frame(4'h7, 16'hC0DE, PPB, 0, 1'b0);
    chk("carrier_ok_back", 32'(carrier_ok), 32'd1);

    // Link down mid-frame: silent abort
    send_head(4'h6);
    swiptAlive = 1'b0;
    repeat (3) send_period(HI1);
    chk("carrier_ok_link_down", 32'(carrier_ok), 32'd0);
    swiptAlive = 1'b1;
    send_frame(4'h1, 16'h5A5A, PPB, 0, 1'b0);

    // One-cycle reset mid-frame
    send_head(4'h4);
    send_word(16'h0003, 3, PPB, 0);
    nrst = 1'b0;
    @(negedge clk);
    nrst   = 1'b1;
    m_idx  = 4'd0;
    m_data = 16'd0;
    chk_zero_outputs("midreset");
    send_frame(4'h4, 16'h8001, PPB, 0, 1'b0);

    if (PAR_EN) begin
      send_frame(4'h0, 16'h0001, PPB, 0, 1'b1);
      send_frame(4'h0, 16'h0001, PPB, 0, 1'b0);
    end

    for (int i = 0; (i < 200) && (q.size() != 0); i++) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/swipt_rx_decoder.md
SWIPT_RX_DECODER -- requirements
Module: swipt_rx_decoder

Interface
REQ-001 SHALL have parameter PERIODS_PER_BIT, default 8: carrier periods per data bit.
REQ-002 SHALL have parameter SYNC_WORD, default 8'hA5: frame start pattern.
REQ-003 SHALL have parameter MAX_PERIOD, default 12'hFFF: clk cycles without a carrier rising edge before the carrier is declared lost.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on posedge.
REQ-005 SHALL have port nrst, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port swiptAlive, input, 1: low means link down; decoder held idle.
REQ-007 SHALL have port swipt_in, input, 1: received carrier comparator output, asynchronous.
REQ-008 SHALL have port word_valid, output, 1: one-cycle strobe, word accepted.
REQ-009 SHALL have port word_idx, output, 4: register index of the accepted word.
REQ-010 SHALL have port word_data, output, 16: payload of the accepted word.
REQ-011 SHALL have port frame_err, output, 1: one-cycle strobe, frame rejected.
REQ-012 SHALL have port carrier_ok, output, 1: high while carrier edges arrive within MAX_PERIOD.

Function
REQ-013 SHALL pass swipt_in through a 2-FF synchronizer and detect rising edges on the synchronized signal.
REQ-014 SHALL count period_cnt (12 bit, saturating) between rising edges and high_cnt (12 bit) of cycles with synchronized input high.
REQ-015 SHALL classify each completed period at its closing rising edge: symbol 1 if (high_cnt<<1) > period_cnt (13-bit compare), else 0.
REQ-016 SHALL form a bit from PERIODS_PER_BIT symbols by majority; a tie resolves to 0.
REQ-017 SHALL align bit boundaries to the first rising edge after reset, carrier loss or frame end.
REQ-018 SHALL run FSM states HUNT, INDEX, DATA, PARITY, DONE.
REQ-019 HUNT: shift bits into an 8-bit register; on match with SYNC_WORD go to INDEX.
REQ-020 INDEX: collect 4 bits MSB first, then go to DATA.
REQ-021 DATA: collect 16 bits MSB first, then go to PARITY when SWIPT_RX_PARITY_EN is defined, else DONE.
REQ-022 DONE: if index <= 4'd8, latch word_idx/word_data and pulse word_valid for one cycle; else pulse frame_err for one cycle; return to HUNT with the sync register cleared, same cycle.
REQ-023 word_idx/word_data SHALL hold their last accepted value until the next word_valid.
REQ-024 When period_cnt reaches MAX_PERIOD, SHALL drop carrier_ok, abort any frame (frame_err pulse if state is not HUNT) and enter HUNT; carrier_ok rises again on the next rising edge.
REQ-025 When swiptAlive is low, SHALL behave as carrier lost, without a frame_err pulse.
REQ-026 A rising edge coinciding with a timeout SHALL count as a valid edge; no timeout occurs in that cycle.

Reset
REQ-027 When nrst is low at posedge clk, SHALL set state HUNT, all counters, shift registers, word_idx, word_data, word_valid, frame_err and carrier_ok to 0.
REQ-028 Reset mid-frame SHALL discard the partial frame with no strobe.

Configuration
REQ-029 With SWIPT_RX_PARITY_EN defined, SHALL expect one even-parity bit over the 20 index+data bits; on mismatch SHALL pulse frame_err instead of word_valid.
REQ-030 Without SWIPT_RX_PARITY_EN, the frame SHALL be 28 bits with no parity state.

Structure
REQ-031 A shared package swipt_pkg SHALL hold the FSM state encoding, SYNC_WORD default, and the index constants 0..8 (SWIPT_P_TX, SWIPT_DUTY, SWIPT_FREQ, SWIPT_ASCII, ANC_MAX_HEIGHT, ANC_MIN_HEIGHT, COMMS_TRAJECT, COMMS_QR_CODES, COMMS_FLIGHT_TIME).
REQ-032 Period measurement and symbol classification SHALL be one sub-module, swipt_duty_slicer.

Verification
REQ-033 35 kHz carrier (2857 cycles), 8 periods/bit, duty 80%=1 / 20%=0, frame A5,4'h2,16'h1234 -> one word_valid, word_idx=2, word_data=16'h1234.
REQ-034 Same frame with index 4'hB -> frame_err pulse, word_data unchanged.
REQ-035 Bit with 5 periods at 80% and 3 at 20% -> bit 1; a 4/4 split -> bit 0.
REQ-036 Carrier stopped mid-DATA for 4096 cycles -> carrier_ok=0, one frame_err, next full frame decodes correctly.
REQ-037 With SWIPT_RX_PARITY_EN, frame A5,4'h0,16'h0001 and parity 0 -> frame_err; parity 1 -> word_valid.
REQ-038 nrst low for 1 cycle mid-frame -> all outputs 0, no strobe, following frame decodes.
